// File: rtl/vga_text_bitgen.sv
// vga_text_bitgen: 80x30 text-mode pixel generator for 640x480 VGA.
// Three-stage pipeline advanced by pix_en: char RAM address, font ROM
// address, then glyph-bit/palette lookup. The sync and bright bits ride
// through the same stages, so they stay aligned with rgb.
module vga_text_bitgen #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int BLINK_BIT = 4
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        bright,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        bright_out
);

  typedef struct packed {
    logic [2:0] px;
    logic [3:0] vrow;
    logic [6:0] col;
    logic [4:0] row;
    logic       hs;
    logic       vs;
    logic       br;
  } s1_t;

  typedef struct packed {
    logic [2:0] px;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       hit;
    logic       hs;
    logic       vs;
    logic       br;
  } s2_t;

  s1_t        s1;
  s2_t        s2;
  logic [4:0] fcnt;

  // vCount[9] is never needed: visible lines stop at 479.
  logic       unused_vcount_msb;
  assign unused_vcount_msb = vCount[9];

  // Fixed RGB332 palette.
  function automatic logic [7:0] pal(input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (idx)
      4'h0: c = 8'h00;  4'h1: c = 8'h02;  4'h2: c = 8'h10;  4'h3: c = 8'h12;
      4'h4: c = 8'h80;  4'h5: c = 8'h82;  4'h6: c = 8'h90;  4'h7: c = 8'hB6;
      4'h8: c = 8'h49;  4'h9: c = 8'h03;  4'hA: c = 8'h1C;  4'hB: c = 8'h1F;
      4'hC: c = 8'hE0;  4'hD: c = 8'hE3;  4'hE: c = 8'hFC;  4'hF: c = 8'hFF;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Row base is a constant multiply, which reduces to shift-and-add.
  logic [11:0] row_base;
  assign row_base = 12'(vCount[8:4]) * 12'(COLS);

  // Cursor hit: blinking underline on glyph rows 14-15 of the cursor cell.
  logic cur_in_range, cur_hit;
  assign cur_in_range = (32'(cursor_col) < COLS) && (32'(cursor_row) < ROWS);
  assign cur_hit = cursor_en && cur_in_range && fcnt[BLINK_BIT] &&
                   (s1.col == cursor_col) && (s1.row == cursor_row) &&
                   (s1.vrow >= 4'd14);

  // Stage 3 glyph bit; bit 7 of the font row is the leftmost pixel.
  logic       glyph_bit;
  logic [3:0] cidx;
  assign glyph_bit = font_data[~s2.px];
  assign cidx      = (glyph_bit ^ s2.hit) ? s2.fg : s2.bg;

  // Stage 1: issue char RAM address and latch position/sync.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      char_addr <= '0;
      s1        <= '0;
      s1.hs     <= 1'b1;
      s1.vs     <= 1'b1;
    end else if (pix_en) begin
      if (bright) char_addr <= row_base + 12'(hCount[9:3]);
      s1.px   <= hCount[2:0];
      s1.vrow <= vCount[3:0];
      s1.col  <= hCount[9:3];
      s1.row  <= vCount[8:4];
      s1.hs   <= hsync;
      s1.vs   <= vsync;
      s1.br   <= bright;
    end
  end

  // Frame counter: counts vsync falling edges seen at the strobe rate.
  always_ff @(posedge clk_50) begin
    if (reset) fcnt <= '0;
    else if (pix_en && s1.vs && !vsync) fcnt <= fcnt + 5'd1;
  end

  // Stage 2: issue font ROM address, latch colours and cursor hit.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      font_addr <= '0;
      s2        <= '0;
      s2.hs     <= 1'b1;
      s2.vs     <= 1'b1;
    end else if (pix_en) begin
      font_addr <= {char_data[7:0], s1.vrow};
      s2.px  <= s1.px;
      s2.fg  <= char_data[11:8];
      s2.bg  <= char_data[15:12];
      s2.hit <= cur_hit;
      s2.hs  <= s1.hs;
      s2.vs  <= s1.vs;
      s2.br  <= s1.br;
    end
  end

  // Stage 3: palette lookup and aligned sync/blank outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      rgb        <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      bright_out <= 1'b0;
    end else if (pix_en) begin
      rgb        <= s2.br ? pal(cidx) : 8'h00;
      hsync_out  <= s2.hs;
      vsync_out  <= s2.vs;
      bright_out <= s2.br;
    end
  end

endmodule

// File: tb/tb_vga_text_bitgen.sv
// tb_vga_text_bitgen: random/directed stimulus against a per-strobe
// reference model of the text renderer (screen memory + glyph lookup).
module tb_vga_text_bitgen;

  logic        clk_50 = 1'b0;
  logic        reset, pix_en;
  logic [9:0]  hCount, vCount;
  logic        hsync, vsync, bright;
  logic [11:0] char_addr, font_addr;
  logic [15:0] char_data;
  logic [7:0]  font_data, rgb;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        hsync_out, vsync_out, bright_out;

  always #10 clk_50 = ~clk_50;

  vga_text_bitgen #(.COLS(80), .ROWS(30), .BLINK_BIT(4)) dut (
    .clk_50(clk_50), .reset(reset), .pix_en(pix_en),
    .hCount(hCount), .vCount(vCount), .hsync(hsync), .vsync(vsync),
    .bright(bright), .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .bright_out(bright_out)
  );

  // Synchronous-read memories, one clock latency.
  logic [15:0] cram [4096];
  logic [7:0]  from [4096];
  always @(posedge clk_50) begin
    char_data <= cram[char_addr];
    font_data <= from[font_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  byte unsigned pal_ref [16] = '{8'h00, 8'h02, 8'h10, 8'h12, 8'h80, 8'h82,
                                 8'h90, 8'hB6, 8'h49, 8'h03, 8'h1C, 8'h1F,
                                 8'hE0, 8'hE3, 8'hFC, 8'hFF};

  // One entry per strobe: what was presented and the model state after it.
  typedef struct {
    int h, v, hs, vs, br;
    int caddr, cnt;
    int cen, ccol, crow;
  } ent_t;
  ent_t hist[$];

  int e_rgb, e_hs, e_vs, e_br, e_ca, e_fa;

  function automatic ent_t reset_ent();
    ent_t e;
    e = '{h:0, v:0, hs:1, vs:1, br:0, caddr:0, cnt:0, cen:0, ccol:0, crow:0};
    return e;
  endfunction

  function automatic int pixel(ent_t p, ent_t c);
    int col, row, vrow, px, w, g, on, cur, idx;
    col = p.h / 8; row = p.v / 16; vrow = p.v % 16; px = p.h % 8;
    w   = cram[row * 80 + col];
    g   = from[(w & 'hFF) * 16 + vrow];
    on  = (g >> (7 - px)) & 1;
    cur = (c.cen != 0 && ((p.cnt >> 4) & 1) == 1 && col == c.ccol &&
           row == c.crow && vrow >= 14) ? 1 : 0;
    idx = ((on ^ cur) != 0) ? ((w >> 8) & 'hF) : ((w >> 12) & 'hF);
    return pal_ref[idx];
  endfunction

  task automatic check_outs(input string sfx);
    chk({"rgb", sfx}, rgb, e_rgb);
    chk({"hsync_out", sfx}, hsync_out, e_hs);
    chk({"vsync_out", sfx}, vsync_out, e_vs);
    chk({"bright_out", sfx}, bright_out, e_br);
    chk({"char_addr", sfx}, char_addr, e_ca);
    chk({"font_addr", sfx}, font_addr, e_fa);
  endtask

  // Idle clocks: inputs wander but nothing may move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b0;
      hCount = 10'($urandom_range(0, 799)); vCount = 10'($urandom_range(0, 524));
      hsync = 1'($urandom); vsync = 1'($urandom); bright = 1'($urandom);
      @(posedge clk_50); #1;
      check_outs("_hold");
    end
  endtask

  task automatic strobe(input int h, input int v, input int hs, input int vs, input int br);
    ent_t e, prev, p, c;
    int gap;
    gap = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(1, 2);
    idle(gap);
    hCount = 10'(h); vCount = 10'(v); hsync = 1'(hs); vsync = 1'(vs); bright = 1'(br);
    pix_en = 1'b1;
    @(posedge clk_50); #1;
    pix_en = 1'b0;
    prev    = hist[hist.size() - 1];
    e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.br = br;
    e.caddr = (br != 0) ? (v / 16) * 80 + h / 8 : prev.caddr;
    e.cnt   = (prev.vs == 1 && vs == 0) ? (prev.cnt + 1) % 32 : prev.cnt;
    e.cen = cursor_en; e.ccol = cursor_col; e.crow = cursor_row;
    hist.push_back(e);
    p = hist[hist.size() - 3];
    c = hist[hist.size() - 2];
    e_rgb = (p.br != 0) ? pixel(p, c) : 0;
    e_hs = p.hs; e_vs = p.vs; e_br = p.br;
    e_ca = e.caddr;
    e_fa = ((cram[c.caddr] & 'hFF) << 4) | (c.v % 16);
    check_outs("");
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_en = 1'($urandom);
      hCount = 10'($urandom); vCount = 10'($urandom);
      hsync = 1'($urandom); vsync = 1'($urandom); bright = 1'($urandom);
      @(posedge clk_50); #1;
      chk("rst_rgb", rgb, 0);
      chk("rst_bright_out", bright_out, 0);
      chk("rst_hsync_out", hsync_out, 1);
      chk("rst_vsync_out", vsync_out, 1);
      chk("rst_char_addr", char_addr, 0);
      chk("rst_font_addr", font_addr, 0);
    end
    reset = 1'b0; pix_en = 1'b0;
    hist = {};
    hist.push_back(reset_ent());
    hist.push_back(reset_ent());
    e_rgb = 0; e_hs = 1; e_vs = 1; e_br = 0; e_ca = 0; e_fa = 0;
  endtask

  task automatic vs_falls(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(700, 500, 1, 1, 0);
      strobe(700, 500, 1, 0, 0);
    end
    strobe(700, 500, 1, 1, 0);
  endtask

  // Visible pixels of cells (3..6, 1..3) around the cursor, glyph rows 12..15.
  task automatic render_cursor_area();
    for (int v = 28; v < 64; v++)
      for (int h = 24; h < 56; h++)
        if ((v % 16) >= 12) strobe(h, v, 1, 1, 1);
  endtask

  initial begin
    int h, v;
    for (int i = 0; i < 4096; i++) begin
      cram[i] = 16'($urandom);
      from[i] = 8'($urandom);
    end
    cram[0] = 16'h0F41;
    from[12'h410] = 8'h81;
    reset = 1'b1; pix_en = 1'b0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    hCount = '0; vCount = '0; hsync = 1'b1; vsync = 1'b1; bright = 1'b0;

    // Reset values under random inputs.
    do_reset(3);

    // Cell 0 'A' pattern: FF,00,...,00,FF once the pipeline fills.
    for (int x = 0; x < 8; x++) strobe(x, 0, 1, 1, 1);
    strobe(8, 0, 1, 1, 1);
    strobe(9, 0, 1, 1, 1);

    // Bottom-right visible corner.
    strobe(639, 479, 1, 1, 1);
    chk("corner_char_addr", char_addr, 2399);
    strobe(640, 479, 1, 1, 0);
    chk("corner_vrow", font_addr & 'hF, 'hF);
    strobe(641, 479, 1, 1, 0);

    // Blanked region with toggling syncs.
    for (int i = 0; i < 40; i++)
      strobe($urandom_range(640, 799), $urandom_range(0, 524),
             $urandom_range(0, 1), $urandom_range(0, 1), 0);

    // Cursor blink at col 5 row 2.
    do_reset(2);
    cursor_en = 1'b1; cursor_col = 7'd5; cursor_row = 5'd2;
    vs_falls(15);
    render_cursor_area();
    vs_falls(1);
    render_cursor_area();
    vs_falls(16);
    render_cursor_area();

    // Random raster positions, random cursor, mid-run reset.
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        cursor_en  = 1'($urandom);
        cursor_col = 7'($urandom);
        cursor_row = 5'($urandom);
      end
      if (i == 400) do_reset(2);
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
      strobe(h, v, (h >= 656 && h < 752) ? 0 : 1, ($urandom_range(0, 3) == 0) ? 0 : 1,
             (h < 640 && v < 480) ? 1 : 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_bitgen.md
Name: vga_text_bitgen

Overview:
- Pixel generator directly downstream of VGA_Timing in the 640x480 @ 60 Hz display path.
- Consumes hCount, vCount, hsync, vsync and bright, and renders an 80x30 text screen of 8x16 glyphs.
- Uses an external character RAM and an external font ROM.
- Outputs RGB332 pixels with the sync and blanking signals delayed to match pipeline latency.
- Provides a blinking underline cursor.

Parameters:
- COLS, 80, characters per row; also the row stride used in address generation.
- ROWS, 30, character rows (range of cursor_row).
- BLINK_BIT, 4, frame-counter bit driving the cursor blink phase (toggles every 2^BLINK_BIT frames).

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  one-clk pixel strobe at 25 MHz; the pipeline advances only when pix_en=1
- hCount  in  10  horizontal pixel count from VGA_Timing (0..799)
- vCount  in  10  vertical line count from VGA_Timing (0..524)
- hsync  in  1  active-low hsync from VGA_Timing
- vsync  in  1  active-low vsync from VGA_Timing
- bright  in  1  high in the visible 640x480 region
- char_addr  out  12  character RAM address, row*COLS+col
- char_data  in  16  character word: [7:0] code, [11:8] fg index, [15:12] bg index
- font_addr  out  12  font ROM address {code, glyph_row[3:0]}
- font_data  in  8  glyph row; bit 7 is the leftmost pixel
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- rgb  out  8  pixel {r[2:0], g[2:0], b[1:0]}
- hsync_out  out  1  hsync delayed to align with rgb
- vsync_out  out  1  vsync delayed to align with rgb
- bright_out  out  1  bright delayed to align with rgb

Behaviour:
- Reset (synchronous, active-high, sampled on every clk_50 edge regardless of pix_en):
  - rgb=0, bright_out=0, hsync_out=1, vsync_out=1, char_addr=0, font_addr=0.
  - All pipeline registers cleared; sync bits inside the pipeline reset to 1.
  - Frame counter cleared to 0.
- Memory contract: both memories are synchronous-read with 1-clk latency. Addresses are held between strobes, so data is valid at the next pix_en.
- Stage 1, on strobe N:
  - If bright=1: char_addr <= (vCount[8:4]<<6)+(vCount[8:4]<<4)+hCount[9:3]. If bright=0, char_addr holds its value.
  - Latch hCount[2:0], vCount[3:0], col=hCount[9:3], row=vCount[8:4], hsync, vsync, bright.
- Stage 2, on strobe N+1:
  - font_addr <= {char_data[7:0], vrow}.
  - Latch fg, bg and cursor_hit. cursor_hit = cursor_en & blink_phase & col==cursor_col & row==cursor_row & vrow>=14.
  - Carry the pixel column and sync/bright bits forward.
- Stage 3, on strobe N+2:
  - bit = font_data[7-px].
  - idx = bit XOR cursor_hit ? fg : bg.
  - rgb <= bright ? palette[idx] : 0.
  - hsync_out, vsync_out and bright_out take the stage-2 copies.
- Latency: inputs sampled at strobe N appear on the outputs after the clk edge of strobe N+2. Sync and bright paths carry identical delay.
- Palette, indices 0..15, fixed combinational: 00,02,10,12,80,82,90,B6,49,03,1C,1F,E0,E3,FC,FF.
- Cursor blink:
  - A 5-bit frame counter increments on the pix_en cycle where the stage-1 vsync copy is 1 and input vsync is 0 (falling edge). It wraps 31->0.
  - blink_phase = counter[BLINK_BIT].
- pix_en=0: all stage registers, outputs and the frame counter hold.
- Range: rows 30..31 and cols 80..127 cannot occur while bright=1. A cursor set outside range never hits.
- Reset mid-frame: outputs take reset values at the next clk. The first valid pixel appears on the third pix_en strobe after reset deasserts.

Test Plan:
1. Assert reset for 3 clks with random inputs -> rgb=00, bright_out=0, hsync_out=1, vsync_out=1, char_addr=0, font_addr=0; frame counter=0.
2. Char RAM[0]=16'h0F41, font[0x410]=8'h81; sweep hCount 0..7, vCount=0, bright=1, pix_en every 2nd clk -> char_addr=0, font_addr=0x410; rgb sequence FF,00,00,00,00,00,00,FF, starting 2 strobes after hCount=0.
3. hCount=639, vCount=479, bright=1 -> char_addr=2399; font_addr[3:0]=4'hF.
4. Toggle hsync/vsync with bright=0, char data all 0xFFFF -> rgb stays 00; hsync_out and vsync_out reproduce the input waveform delayed by exactly 2 strobes.
5. Cursor at col 5, row 2, cursor_en=1, glyph blank (font_data=0), fg=15, bg=0:
   - After 15 vsync falls -> no inversion.
   - After the 16th fall -> glyph rows 14 and 15 of cell (5,2) read FF; rows 0..13 and neighbouring cells read 00.
   - After 32 falls -> inversion off again.
6. Hold pix_en=0 for 10 clks mid-line -> rgb, syncs, char_addr and font_addr unchanged. Resuming continues the sequence without skipped or duplicated pixels.
